// File: rtl/adders_if.sv
// adders_if: operand/result bundle for the registered adder block.
//   master : drives in_valid, a, b, c, a_n, b_n; receives registered results
//   slave  : the adder block; receives operands, drives out_valid, half_sum,
//            half_carry, sum, carry, out_n, cout_n (and ovf_n when
//            ADDERS_OVERFLOW_EN is defined)
// Macro: ADDERS_OVERFLOW_EN adds the signed-overflow result ovf_n.
interface adders_if #(parameter int N = 32);
   logic         in_valid;
   logic         a;
   logic         b;
   logic         c;
   logic [N-1:0] a_n;
   logic [N-1:0] b_n;
   logic         out_valid;
   logic         half_sum;
   logic         half_carry;
   logic         sum;
   logic         carry;
   logic [N-1:0] out_n;
   logic         cout_n;
`ifdef ADDERS_OVERFLOW_EN
   logic         ovf_n;
   modport master (output in_valid, a, b, c, a_n, b_n,
                   input out_valid, half_sum, half_carry, sum, carry, out_n, cout_n, ovf_n);
   modport slave (input in_valid, a, b, c, a_n, b_n,
                  output out_valid, half_sum, half_carry, sum, carry, out_n, cout_n, ovf_n);
`else
   modport master (output in_valid, a, b, c, a_n, b_n,
                   input out_valid, half_sum, half_carry, sum, carry, out_n, cout_n);
   modport slave (input in_valid, a, b, c, a_n, b_n,
                  output out_valid, half_sum, half_carry, sum, carry, out_n, cout_n);
`endif
endinterface

// File: rtl/adders.sv
// adders: registered half adder, full adder and N-bit ripple-carry adder.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears every output register
//   bus   : adders_if.slave carrying operands (in_valid, a, b, c, a_n, b_n)
//           and registered results (out_valid, half_sum, half_carry, sum,
//           carry, out_n, cout_n, ovf_n)
// Macro: ADDERS_OVERFLOW_EN enables the registered signed-overflow flag ovf_n.

// adders_ha: combinational half adder cell.
module adders_ha (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   assign s  = a ^ b;
   assign co = a & b;
endmodule

// adders_fa: full adder built from two half adders and an OR.
module adders_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s0, c0, c1;
   adders_ha u_ha0 (.a(a),  .b(b),  .s(s0), .co(c0));
   adders_ha u_ha1 (.a(s0), .b(ci), .s(s),  .co(c1));
   assign co = c0 | c1;
endmodule

module adders #(parameter int N = 32) (
   input logic   clk,
   input logic   rst_n,
   adders_if.slave bus
);
   logic         ha_s, ha_c, fa_s, fa_c;
   logic [N:0]   cy;
   logic [N-1:0] sum_n;
   adders_ha u_ha (.a(bus.a), .b(bus.b), .s(ha_s), .co(ha_c));
   adders_fa u_fa (.a(bus.a), .b(bus.b), .ci(bus.c), .s(fa_s), .co(fa_c));
   // Ripple chain: bit 0 has no carry-in, each cell feeds the next.
   assign cy[0] = 1'b0;
   for (genvar i = 0; i < N; i++) begin : g_rc
      adders_fa u_cell (.a(bus.a_n[i]), .b(bus.b_n[i]), .ci(cy[i]), .s(sum_n[i]), .co(cy[i+1]));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.half_sum   <= 1'b0;
         bus.half_carry <= 1'b0;
         bus.sum        <= 1'b0;
         bus.carry      <= 1'b0;
         bus.out_n      <= '0;
         bus.cout_n     <= 1'b0;
`ifdef ADDERS_OVERFLOW_EN
         bus.ovf_n      <= 1'b0;
`endif
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.half_sum   <= ha_s;
            bus.half_carry <= ha_c;
            bus.sum        <= fa_s;
            bus.carry      <= fa_c;
            bus.out_n      <= sum_n;
            bus.cout_n     <= cy[N];
`ifdef ADDERS_OVERFLOW_EN
            // Same-sign operands whose result sign differs.
            bus.ovf_n      <= (bus.a_n[N-1] == bus.b_n[N-1]) && (sum_n[N-1] != bus.a_n[N-1]);
`endif
         end
      end
   end
endmodule

// File: tb/tb_adders.sv
// tb_adders: table-driven, directed and randomized checks of adders (N = 32).
module tb_adders;
   localparam int N = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   adders_if #(.N(N)) bus();
   adders #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic a, b, c;
      logic [N-1:0] an, bn;
      logic hs, hc, s, cy;
      logic [N-1:0] on;
      logic co;
   } vec_t;
   vec_t tbl[8];

   // Expected register contents, derived from plain arithmetic.
   logic m_v, m_hs, m_hc, m_s, m_c, m_co, m_ov;
   logic [N-1:0] m_on;

   task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic v, logic a, logic b, logic c, logic [N-1:0] an, logic [N-1:0] bn);
      bus.in_valid = v;
      bus.a = a;
      bus.b = b;
      bus.c = c;
      bus.a_n = an;
      bus.b_n = bn;
   endtask

   task automatic tick();
      logic [N:0] t;
      longint sv;
      if (!rst_n) begin
         {m_v, m_hs, m_hc, m_s, m_c, m_co, m_ov} = '0;
         m_on = '0;
      end else begin
         m_v = bus.in_valid;
         if (bus.in_valid) begin
            {m_hc, m_hs} = 2'(bus.a) + 2'(bus.b);
            {m_c, m_s} = 2'(bus.a) + 2'(bus.b) + 2'(bus.c);
            t = {1'b0, bus.a_n} + {1'b0, bus.b_n};
            {m_co, m_on} = t;
            sv = longint'($signed(bus.a_n)) + longint'($signed(bus.b_n));
            m_ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(string tag);
      chk({tag, ".out_valid"}, N'(bus.out_valid), N'(m_v));
      chk({tag, ".half_sum"}, N'(bus.half_sum), N'(m_hs));
      chk({tag, ".half_carry"}, N'(bus.half_carry), N'(m_hc));
      chk({tag, ".sum"}, N'(bus.sum), N'(m_s));
      chk({tag, ".carry"}, N'(bus.carry), N'(m_c));
      chk({tag, ".out_n"}, bus.out_n, m_on);
      chk({tag, ".cout_n"}, N'(bus.cout_n), N'(m_co));
`ifdef ADDERS_OVERFLOW_EN
      chk({tag, ".ovf_n"}, N'(bus.ovf_n), N'(m_ov));
`endif
   endtask

   task automatic check_zero(string tag);
      chk({tag, ".out_valid"}, N'(bus.out_valid), '0);
      chk({tag, ".bits"}, N'({bus.half_sum, bus.half_carry, bus.sum, bus.carry, bus.cout_n}), '0);
      chk({tag, ".out_n"}, bus.out_n, '0);
`ifdef ADDERS_OVERFLOW_EN
      chk({tag, ".ovf_n"}, N'(bus.ovf_n), '0);
`endif
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h55555555, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hACF13568, 1'b0};

      // Reset held with every input asserted.
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, '1, '1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_zero("reset");
      end
      rst_n = 1'b1;

      // Exhaustive 1-bit cases paired with N-bit corner operands.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].an, tbl[k].bn);
         tick();
         chk($sformatf("tbl%0d.out_valid", k), N'(bus.out_valid), N'(1'b1));
         chk($sformatf("tbl%0d.half_sum", k), N'(bus.half_sum), N'(tbl[k].hs));
         chk($sformatf("tbl%0d.half_carry", k), N'(bus.half_carry), N'(tbl[k].hc));
         chk($sformatf("tbl%0d.sum", k), N'(bus.sum), N'(tbl[k].s));
         chk($sformatf("tbl%0d.carry", k), N'(bus.carry), N'(tbl[k].cy));
         chk($sformatf("tbl%0d.out_n", k), bus.out_n, tbl[k].on);
         chk($sformatf("tbl%0d.cout_n", k), N'(bus.cout_n), N'(tbl[k].co));
`ifdef ADDERS_OVERFLOW_EN
         chk($sformatf("tbl%0d.ovf_n", k), N'(bus.ovf_n), N'(k == 4 || k == 5));
`endif
      end

      // Hold: results stay put while in_valid is low.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h22222222);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("hold.out_valid", N'(bus.out_valid), '0);
         chk("hold.out_n", bus.out_n, 32'h0);
         chk("hold.cout_n", N'(bus.cout_n), N'(1'b1));
         chk("hold.sum_carry", N'({bus.sum, bus.carry, bus.half_sum, bus.half_carry}), N'(4'b0110));
      end

      // Reset mid-stream drops the operation presented on the same edge.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h00000010, 32'h00000020);
      tick();
      check_all("pre_mid");
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 32'h00000001);
      tick();
      check_zero("mid_reset");
      rst_n = 1'b1;
      tick();
      chk("after_reset.out_n", bus.out_n, 32'h00010000);
      chk("after_reset.out_valid", N'(bus.out_valid), N'(1'b1));
      check_all("after_reset");

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         rst_n = ($urandom_range(0, 31) != 0);
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? '1 : N'($urandom),
               ($urandom_range(0, 7) == 0) ? 32'h80000000 : N'($urandom));
         tick();
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
